// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory with a registered, stallable fetch port
module imem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_start,
  input  logic              i_load_we,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_done,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_load_ovf,
  output logic              o_busy,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_ready,
  input  logic              i_stall,
  output logic              o_fetch_valid,
  output logic [DATA_W-1:0] o_fetch_instr,
  output logic              o_fetch_fault
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf, r_valid, r_fault;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_full, w_hit, w_we, w_ready, w_accept;
  always_comb begin
    w_full   = r_count == (ADDR_W+1)'(DEPTH);
    w_hit    = {1'b0, i_fetch_addr} < r_count;
    w_we     = (r_state == LOADING) && i_load_we && !i_load_start && !w_full;
    w_ready  = (r_state == READY) && !i_load_start && !(r_valid && i_stall);
    w_accept = w_ready && i_fetch_req;
    w_next   = i_load_start ? LOADING :
               ((r_state == LOADING) && i_load_done) ? READY : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (i_load_start) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if ((r_state == LOADING) && i_load_we) begin
        if (w_full) r_ovf <= 1'b1;
        else r_count <= r_count + 1'b1;
      end
      // load_start flushes the output even while stalled
      if (i_load_start) r_valid <= 1'b0;
      else if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= w_hit ? r_mem[i_fetch_addr[IDX_W-1:0]] : NOP_WORD;
        r_fault <= !w_hit;
      end else if (!(r_valid && i_stall)) r_valid <= 1'b0;
    end
  always_ff @(posedge clk)
    if (w_we) r_mem[r_count[IDX_W-1:0]] <= i_load_data;
  assign o_load_count  = r_count;
  assign o_load_ovf    = r_ovf;
  assign o_busy        = r_state == LOADING;
  assign o_fetch_ready = w_ready;
  assign o_fetch_valid = r_valid;
  assign o_fetch_instr = r_instr;
  assign o_fetch_fault = r_fault;
endmodule
